// File: rtl/window_linebuf_gen.sv
`default_nettype none
// ============================================================================
// Module   : window_linebuf_gen
// Purpose  : Streaming K x K sliding-window generator (K = 3 or 5, stride 1/2)
//            over a raster pixel stream with runtime frame geometry.
// Revision : 1.0
// ============================================================================

module window_linebuf_gen #(
    parameter int DATA_W = 14,
    parameter int MAX_W  = 116,
    parameter int MAX_H  = 116,
    parameter int K_MAX  = 5
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [2:0]                    cfg_k,
    input  logic [1:0]                    cfg_stride,
    input  logic [$clog2(MAX_W+1)-1:0]    cfg_width,
    input  logic [$clog2(MAX_H+1)-1:0]    cfg_height,
    input  logic                          in_valid,
    input  logic signed [DATA_W-1:0]      in_pixel,
    output logic                          in_ready,
    output logic                          win_valid,
    input  logic                          win_ready,
    output logic [K_MAX*K_MAX*DATA_W-1:0] win_data,
    output logic                          busy,
    output logic                          frame_done,
    output logic                          cfg_err
);

    localparam int c_WB   = $clog2(MAX_W+1);
    localparam int c_HB   = $clog2(MAX_H+1);
    localparam int c_ROWS = K_MAX - 1;
    localparam int c_LW   = K_MAX * K_MAX * DATA_W;

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_RUN   = 2'd1;
    localparam logic [1:0] c_FLUSH = 2'd2;

    logic [1:0]             r_state;
    logic [2:0]             r_k;
    logic [1:0]             r_stride;
    logic [c_WB-1:0]        r_width;
    logic [c_HB-1:0]        r_height;
    logic [c_WB-1:0]        r_col;
    logic [c_HB-1:0]        r_row;
    logic                   r_win_valid;
    logic [c_LW-1:0]        r_win_data;
    logic                   r_frame_done;
    logic                   r_cfg_err;

    // r_lb[j][x]: pixel j+1 rows above the current row at column x
    logic signed [DATA_W-1:0] r_lb [c_ROWS][MAX_W];
    // r_cs[a][d]: column (a+1) positions to the left, row delay d
    logic signed [DATA_W-1:0] r_cs [c_ROWS][K_MAX];

    logic signed [DATA_W-1:0] w_col [K_MAX];
    logic [c_LW-1:0]        w_win;
    logic                   w_cfg_ok;
    logic                   w_accept;
    logic                   w_emit;
    logic [2:0]             w_km1;
    logic                   w_col_last;
    logic                   w_row_last;
    logic                   w_stride_ok;

    assign w_cfg_ok = ((cfg_k == 3'd3) || (cfg_k == 3'd5))
                   && ((cfg_stride == 2'd1) || (cfg_stride == 2'd2))
                   && (cfg_width  >= c_WB'(cfg_k)) && (cfg_width  <= c_WB'(MAX_W))
                   && (cfg_height >= c_HB'(cfg_k)) && (cfg_height <= c_HB'(MAX_H));

    assign in_ready   = (r_state == c_RUN) && !start && (!r_win_valid || win_ready);
    assign w_accept   = in_valid && in_ready;
    assign w_km1      = r_k - 3'd1;
    assign w_col_last = (r_col == r_width  - c_WB'(1));
    assign w_row_last = (r_row == r_height - c_HB'(1));

    // Stride 2 keeps only positions whose offset from k-1 is even
    assign w_stride_ok = (r_stride == 2'd1)
                      || (!(r_row[0] ^ w_km1[0]) && !(r_col[0] ^ w_km1[0]));
    assign w_emit = (r_row >= c_HB'(w_km1)) && (r_col >= c_WB'(w_km1)) && w_stride_ok;

    assign w_col[0] = in_pixel;
    for (genvar gd = 1; gd < K_MAX; gd++) begin : g_tap
        assign w_col[gd] = r_lb[gd-1][r_col];
    end

    // Each lane picks from the K_MAX-sized or the 3x3 arrangement; 3x3 leaves outer lanes zero
    for (genvar gr = 0; gr < K_MAX; gr++) begin : g_row
        for (genvar gc = 0; gc < K_MAX; gc++) begin : g_lane
            logic signed [DATA_W-1:0] w_big;
            logic signed [DATA_W-1:0] w_small;
            if (gc == K_MAX-1) begin : g_big_cur
                assign w_big = w_col[K_MAX-1-gr];
            end else begin : g_big_old
                assign w_big = r_cs[K_MAX-2-gc][K_MAX-1-gr];
            end
            if (gr < 3 && gc == 2) begin : g_small_cur
                assign w_small = w_col[2-gr];
            end else if (gr < 3 && gc < 2) begin : g_small_old
                assign w_small = r_cs[1-gc][2-gr];
            end else begin : g_small_zero
                assign w_small = '0;
            end
            assign w_win[(gr*K_MAX+gc)*DATA_W +: DATA_W] = (r_k == 3'd5) ? w_big : w_small;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= c_IDLE;
            r_k          <= '0;
            r_stride     <= '0;
            r_width      <= '0;
            r_height     <= '0;
            r_col        <= '0;
            r_row        <= '0;
            r_win_valid  <= 1'b0;
            r_win_data   <= '0;
            r_frame_done <= 1'b0;
            r_cfg_err    <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (start) begin
                r_win_valid <= 1'b0;
                r_col       <= '0;
                r_row       <= '0;
                if (w_cfg_ok) begin
                    r_k       <= cfg_k;
                    r_stride  <= cfg_stride;
                    r_width   <= cfg_width;
                    r_height  <= cfg_height;
                    r_cfg_err <= 1'b0;
                    r_state   <= c_RUN;
                end else begin
                    r_cfg_err <= 1'b1;
                    r_state   <= c_IDLE;
                end
            end else begin
                if (win_ready) begin
                    r_win_valid <= 1'b0;
                end
                case (r_state)
                    c_RUN: begin
                        if (w_accept) begin
                            if (w_emit) begin
                                r_win_valid <= 1'b1;
                                r_win_data  <= w_win;
                            end
                            if (w_col_last) begin
                                r_col <= '0;
                                if (w_row_last) begin
                                    r_state <= c_FLUSH;
                                end else begin
                                    r_row <= r_row + c_HB'(1);
                                end
                            end else begin
                                r_col <= r_col + c_WB'(1);
                            end
                        end
                    end
                    c_FLUSH: begin
                        if (!r_win_valid || win_ready) begin
                            r_frame_done <= 1'b1;
                            r_state      <= c_IDLE;
                        end
                    end
                    default: r_state <= c_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int j = 0; j < c_ROWS; j++) begin
                for (int x = 0; x < MAX_W; x++) begin
                    r_lb[j][x] <= '0;
                end
                for (int d = 0; d < K_MAX; d++) begin
                    r_cs[j][d] <= '0;
                end
            end
        end else if (start && w_cfg_ok) begin
            for (int j = 0; j < c_ROWS; j++) begin
                for (int x = 0; x < MAX_W; x++) begin
                    r_lb[j][x] <= '0;
                end
                for (int d = 0; d < K_MAX; d++) begin
                    r_cs[j][d] <= '0;
                end
            end
        end else if (w_accept) begin
            for (int j = 0; j < c_ROWS; j++) begin
                r_lb[j][r_col] <= w_col[j];
            end
            for (int d = 0; d < K_MAX; d++) begin
                r_cs[0][d] <= w_col[d];
                for (int a = 1; a < c_ROWS; a++) begin
                    r_cs[a][d] <= r_cs[a-1][d];
                end
            end
        end
    end

    assign win_valid  = r_win_valid;
    assign win_data   = r_win_data;
    assign busy       = (r_state != c_IDLE);
    assign frame_done = r_frame_done;
    assign cfg_err    = r_cfg_err;

endmodule

`default_nettype wire
